// File: rtl/chip8_gfx_pkg.sv
// Shared types and screen constants for the CHIP-8 display path.
package chip8_gfx_pkg;

  localparam int SCREEN_W  = 64;
  localparam int SCREEN_H  = 32;
  localparam int FB_PIXELS = SCREEN_W * SCREEN_H;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FETCH = 3'd2,
    ROW   = 3'd3,
    DONE  = 3'd4
  } blit_state_t;

  // x and y are kept already reduced modulo the screen size.
  typedef struct packed {
    logic        clear;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  n;
    logic [15:0] index;
  } blit_cmd_t;

  function automatic logic [31:0] pixel_word(input logic lit,
                                             input logic [31:0] on_c,
                                             input logic [31:0] off_c);
    return lit ? on_c : off_c;
  endfunction

endpackage

// File: rtl/chip8_sprite_row_xor.sv
// XORs one 8-pixel sprite byte into a 64-pixel framebuffer row.
// SPRITE_WRAP_EN: columns past the right edge wrap instead of being clipped.
module chip8_sprite_row_xor
  import chip8_gfx_pkg::*;
(
  input  logic [SCREEN_W-1:0] row_in,
  input  logic [7:0]          sprite,
  input  logic [5:0]          x0,
  output logic [SCREEN_W-1:0] row_out,
  output logic                hit
);

  logic [6:0] col;

  // Bit 7 of the sprite lands on x0, bit 0 on x0+7. The eight target
  // columns are always distinct, so checking hits against row_in is exact.
  always_comb begin
    row_out = row_in;
    hit     = 1'b0;
    col     = '0;
    for (int i = 0; i < 8; i++) begin
      col = {1'b0, x0} + 7'(i);
      if (sprite[3'(7 - i)]) begin
`ifdef SPRITE_WRAP_EN
        hit              = hit | row_in[col[5:0]];
        row_out[col[5:0]] = ~row_in[col[5:0]];
`else
        if (!col[6]) begin
          hit              = hit | row_in[col[5:0]];
          row_out[col[5:0]] = ~row_in[col[5:0]];
        end
`endif
      end
    end
  end

endmodule

// File: rtl/chip8_sprite_blitter.sv
// CHIP-8 framebuffer owner: executes DRW/CLS, fetches sprite rows, drives vram.
// SPRITE_WRAP_EN: sprite pixels past the right/bottom edge wrap instead of clipping.
module chip8_sprite_blitter
  import chip8_gfx_pkg::*;
#(
  parameter int          SCREEN_W  = chip8_gfx_pkg::SCREEN_W,
  parameter int          SCREEN_H  = chip8_gfx_pkg::SCREEN_H,
  parameter logic [31:0] ON_COLOR  = 32'hFFFFFFFF,
  parameter logic [31:0] OFF_COLOR = 32'h00000000
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_clear,
  input  logic [7:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [3:0]  cmd_n,
  input  logic [15:0] cmd_index,
  output logic        mem_rd_en,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        done,
  output logic        collision,
  output logic [31:0] vram [0:SCREEN_W*SCREEN_H-1],
  output logic [2:0]  dbg_state
);

  // Handshake: a command transfers on a clk_in edge where cmd_valid and
  // cmd_ready are both high. cmd_ready is high only in IDLE and never depends
  // on cmd_valid; requests presented while busy are dropped, not queued.

  blit_state_t         state_q, state_d;
  blit_cmd_t           cmd_q;
  logic [3:0]          r_q;
  logic                collision_q;
  logic [SCREEN_W-1:0] fb [SCREEN_H];

  logic [5:0]          row_sum;
  logic [4:0]          row_idx;
  logic                row_ok;
  logic [SCREEN_W-1:0] row_new;
  logic                row_hit;
  logic                unused_bits;

  assign unused_bits = ^{cmd_x[7:6], cmd_y[7:5], cmd_q.index[15:12], cmd_q.clear};

  assign row_sum = {1'b0, cmd_q.y} + {2'b0, r_q};
  assign row_idx = row_sum[4:0];
`ifdef SPRITE_WRAP_EN
  assign row_ok  = 1'b1;
`else
  assign row_ok  = !row_sum[5];
`endif

  chip8_sprite_row_xor u_row_xor (
    .row_in  (fb[row_idx]),
    .sprite  (mem_data),
    .x0      (cmd_q.x),
    .row_out (row_new),
    .hit     (row_hit)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_clear)         state_d = CLEAR;
          else if (cmd_n == 4'd0) state_d = DONE;
          else                    state_d = FETCH;
        end
      end
      CLEAR: state_d = DONE;
      FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = cmd_q.index[11:0] + {8'b0, r_q};
        state_d   = ROW;
      end
      ROW:  state_d = (r_q + 4'd1 == cmd_q.n) ? DONE : FETCH;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      r_q         <= '0;
      collision_q <= 1'b0;
      for (int i = 0; i < SCREEN_H; i++) fb[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q       <= '{clear: cmd_clear, x: cmd_x[5:0], y: cmd_y[4:0],
                             n: cmd_n, index: cmd_index};
            r_q         <= '0;
            collision_q <= 1'b0;
          end
        end
        CLEAR: begin
          for (int i = 0; i < SCREEN_H; i++) fb[i] <= '0;
        end
        ROW: begin
          r_q <= r_q + 4'd1;
          // Rows below the screen are skipped entirely in the clipping build.
          if (row_ok) begin
            fb[row_idx] <= row_new;
            collision_q <= collision_q | row_hit;
          end
        end
        default: ;
      endcase
    end
  end

  assign collision = collision_q;
  assign dbg_state = state_q;

  for (genvar gy = 0; gy < SCREEN_H; gy++) begin : g_row
    for (genvar gx = 0; gx < SCREEN_W; gx++) begin : g_col
      assign vram[gy*SCREEN_W + gx] = pixel_word(fb[gy][gx], ON_COLOR, OFF_COLOR);
    end
  end

endmodule

// File: tb/tb_chip8_sprite_blitter.sv
// Directed bench for chip8_sprite_blitter with a pixel-level screen model.
module tb_chip8_sprite_blitter;

  localparam logic [31:0] ON_C  = 32'hFFFFFFFF;
  localparam logic [31:0] OFF_C = 32'h00000000;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [7:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic [3:0]  cmd_n;
  logic [15:0] cmd_index;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        done;
  logic        collision;
  logic [31:0] vram [0:2047];
  logic [2:0]  dbg_state;

  // clock / reset
  always #5 clk_in = ~clk_in;

  chip8_sprite_blitter dut (
    .clk_in    (clk_in),
    .rst_in_n  (rst_in_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_clear (cmd_clear),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_n     (cmd_n),
    .cmd_index (cmd_index),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .done      (done),
    .collision (collision),
    .vram      (vram),
    .dbg_state (dbg_state)
  );

  // main memory with one-cycle read latency
  logic [7:0] mem [0:4095];
  always @(posedge clk_in) if (mem_rd_en) mem_data <= mem[mem_addr];

  // screen model and scoreboard state
  bit          exp_fb [0:31][0:63];
  bit          exp_col;
  int          exp_lat;
  logic [11:0] exp_q[$];
  logic [11:0] got_addr[$];
  int          checks = 0;
  int          errors = 0;
  bit          busy = 1'b0;
  int          k;
  int          cur_n;
  bit          cur_clr;
  int          last_done_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic vram_cmp(input string name);
    int bad = 0;
    int first = -1;
    logic [31:0] e, first_got, first_exp;
    first_got = '0;
    first_exp = '0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++) begin
        e = exp_fb[y][x] ? ON_C : OFF_C;
        if (vram[y*64 + x] !== e) begin
          if (bad == 0) begin
            first     = y*64 + x;
            first_got = vram[y*64 + x];
            first_exp = e;
          end
          bad++;
        end
      end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d pixels differ, first index %0d got %0h expected %0h at %0t",
               name, bad, first, first_got, first_exp, $time);
    end
  endtask

  // Screen-level effect of one command, straight from the drawing rules.
  task automatic model_apply(input bit clr, input logic [7:0] x, input logic [7:0] y,
                             input logic [3:0] n, input logic [15:0] idx);
    int a, xx, yy;
    logic [7:0] b;
    exp_col = 1'b0;
    if (clr) begin
      exp_lat = 2;
      for (int r = 0; r < 32; r++)
        for (int c = 0; c < 64; c++) exp_fb[r][c] = 1'b0;
    end else begin
      exp_lat = (n == 0) ? 1 : 2*int'(n) + 1;
      for (int r = 0; r < int'(n); r++) begin
        a = (int'(idx) + r) % 4096;
        exp_q.push_back(a[11:0]);
        b = mem[a];
        for (int i = 0; i < 8; i++) begin
          if (b[7 - i]) begin
            xx = (int'(x) % 64) + i;
            yy = (int'(y) % 32) + r;
`ifdef SPRITE_WRAP_EN
            xx = xx % 64;
            yy = yy % 32;
`else
            if (xx >= 64 || yy >= 32) continue;
`endif
            if (exp_fb[yy][xx]) exp_col = 1'b1;
            exp_fb[yy][xx] = !exp_fb[yy][xx];
          end
        end
      end
    end
  endtask

  // Per-cycle compare while a command is in flight (k = cycles after acceptance).
  task automatic compare_cycle();
    bit exp_rd;
    k++;
    exp_rd = !cur_clr && cur_n != 0 && (k % 2 == 1) && k < 2*cur_n;
    chk("cmd_ready_busy", cmd_ready, 1'b0);
    chk("done_timing", done, k == exp_lat);
    chk("mem_rd_en", mem_rd_en, exp_rd);
    if (mem_rd_en) begin
      got_addr.push_back(mem_addr);
      if (exp_q.size() > 0) chk("mem_addr", mem_addr, exp_q.pop_front());
      else begin
        checks++;
        errors++;
        $display("FAIL mem_addr_extra: got read of %0h, expected none at %0t", mem_addr, $time);
      end
    end
    if (done && last_done_k < 0) last_done_k = k;
    if (k == exp_lat) begin
      chk("collision", collision, exp_col);
      chk("reads_missing", exp_q.size(), 0);
      vram_cmp("vram_after_cmd");
      busy = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk_in);
    if (busy) compare_cycle();
  endtask

  // driver
  task automatic run_cmd(input bit clr, input logic [7:0] x, input logic [7:0] y,
                         input logic [3:0] n, input logic [15:0] idx);
    int guard = 0;
    step();
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_clear = clr;
    cmd_x     = x;
    cmd_y     = y;
    cmd_n     = n;
    cmd_index = idx;
    exp_q.delete();
    got_addr.delete();
    model_apply(clr, x, y, n, idx);
    cur_n       = int'(n);
    cur_clr     = clr;
    last_done_k = -1;
    @(posedge clk_in);
    #1;
    cmd_valid = 1'b0;
    k         = 0;
    busy      = 1'b1;
    while (busy && guard < 100) begin
      step();
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: no completion after %0d cycles", guard);
      busy = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) exp_fb[r][c] = 1'b0;
    mem[0] = 8'hF0; mem[1] = 8'h90; mem[2] = 8'h90; mem[3] = 8'h90; mem[4] = 8'hF0;
    mem[16] = 8'hF0;
    mem[32] = 8'h80;
    mem[4095] = 8'hAA;
    rst_in_n  = 1'b0;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_n     = '0;
    cmd_index = '0;

    // reset state
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_collision", collision, 1'b0);
    chk("rst_mem_rd_en", mem_rd_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 12'h000);
    chk("rst_state", dbg_state, 3'd0);
    vram_cmp("rst_vram");
    rst_in_n = 1'b1;

    // font "0" at the origin
    run_cmd(1'b0, 8'd0, 8'd0, 4'd5, 16'h0000);
    chk("t1_latency", last_done_k, 11);
    chk("t1_collision", collision, 1'b0);
    chk("t1_px_0_0", vram[0], ON_C);
    chk("t1_px_3_0", vram[3], ON_C);
    chk("t1_px_4_0", vram[4], OFF_C);
    chk("t1_px_1_1", vram[64 + 1], OFF_C);
    chk("t1_px_3_2", vram[2*64 + 3], ON_C);
    chk("t1_px_3_4", vram[4*64 + 3], ON_C);

    // same draw again erases it and collides
    run_cmd(1'b0, 8'd0, 8'd0, 4'd5, 16'h0000);
    chk("t2_collision", collision, 1'b1);
    chk("t2_px_0_0", vram[0], OFF_C);

    // right edge
    run_cmd(1'b0, 8'd62, 8'd0, 4'd1, 16'd16);
    chk("t3_collision", collision, 1'b0);
    chk("t3_px_62_0", vram[62], ON_C);
    chk("t3_px_63_0", vram[63], ON_C);
`ifdef SPRITE_WRAP_EN
    chk("t3_px_0_0_wrap", vram[0], ON_C);
    chk("t3_px_1_0_wrap", vram[1], ON_C);
`else
    chk("t3_px_0_0_clip", vram[0], OFF_C);
    chk("t3_px_1_0_clip", vram[1], OFF_C);
`endif

    // start coordinates wrap; address wraps at 4 KiB
    run_cmd(1'b0, 8'd66, 8'd33, 4'd1, 16'd32);
    chk("t4_px_2_1", vram[64 + 2], ON_C);
    run_cmd(1'b0, 8'd20, 8'd10, 4'd2, 16'h0FFF);
    chk("t4_nreads", got_addr.size(), 2);
    chk("t4_addr0", got_addr[0], 12'hFFF);
    chk("t4_addr1", got_addr[1], 12'h000);
    chk("t4_px_20_10", vram[10*64 + 20], ON_C);

    // bottom edge: rows 32..34 clip (or wrap to 0..2)
    run_cmd(1'b0, 8'd5, 8'd30, 4'd5, 16'h0000);
    chk("t4b_px_5_31", vram[31*64 + 5], ON_C);

    // n = 0 leaves the screen alone
    run_cmd(1'b0, 8'd0, 8'd0, 4'd0, 16'h0000);
    chk("t5_n0_latency", last_done_k, 1);

    // collide, then CLS clears screen and flag
    run_cmd(1'b0, 8'd40, 8'd5, 4'd5, 16'h0000);
    run_cmd(1'b0, 8'd40, 8'd5, 4'd5, 16'h0000);
    chk("t5_pre_cls_collision", collision, 1'b1);
    run_cmd(1'b1, 8'd0, 8'd0, 4'd0, 16'h0000);
    chk("t5_cls_latency", last_done_k, 2);
    chk("t5_cls_collision", collision, 1'b0);

    // reset in the middle of a draw
    run_cmd(1'b0, 8'd10, 8'd5, 4'd5, 16'h0000);
    run_cmd(1'b0, 8'd11, 8'd5, 4'd5, 16'h0000);
    chk("t6_pre_collision", collision, 1'b1);
    step();
    cmd_valid = 1'b1;
    cmd_clear = 1'b0;
    cmd_x     = 8'd20;
    cmd_y     = 8'd20;
    cmd_n     = 4'd5;
    cmd_index = 16'h0000;
    @(posedge clk_in);
    #1;
    cmd_valid = 1'b0;
    step();
    step();
    chk("t6_in_row", dbg_state, 3'd3);
    rst_in_n = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in_n = 1'b1;
    step();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) exp_fb[r][c] = 1'b0;
    chk("t6_cmd_ready", cmd_ready, 1'b1);
    chk("t6_done", done, 1'b0);
    chk("t6_collision", collision, 1'b0);
    chk("t6_mem_rd_en", mem_rd_en, 1'b0);
    vram_cmp("t6_vram");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_done", done, 1'b0);
    end

    // still operational afterwards
    run_cmd(1'b0, 8'd0, 8'd0, 4'd5, 16'h0000);
    chk("t7_collision", collision, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
